uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
UART receiver for the SoC's RXD pin. It deserialises 8N1 frames at a fixed clocks-per-bit rate and buffers the received bytes in a small first-word-fall-through (FWFT) FIFO. The FIFO is drained by the CPU-side UART register through a valid/ready pop handshake. The block sits directly downstream of the board/bench RXD line and upstream of the memory-mapped UART data/status registers.

Parameters:
CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200); legal range 8 or more.
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, 2 or more.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rxd  in  1  raw asynchronous serial input; idle level is 1
rx_data  out  8  byte at the FIFO head; valid only while rx_valid=1
rx_valid  out  1  FIFO not empty
rx_ready  in  1  pop request; a pop occurs on any cycle where rx_valid & rx_ready
frame_err  out  1  sticky flag: a stop bit was sampled as 0
overrun  out  1  sticky flag: a byte was dropped because the FIFO was full
err_clr  in  1  single-cycle pulse that clears frame_err and overrun
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy of the FIFO

Behaviour:
- Reset (asynchronous): rx_data=0, rx_valid=0, frame_err=0, overrun=0, fifo_count=0. FSM goes to IDLE. Both synchroniser flops go to 1. A reset in the middle of a frame discards the partial byte.
- rxd passes through a 2-flop synchroniser; the FSM sees only rxd_s.
- Bit counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits.
- FSM states:
  - IDLE: when rxd_s=0, load counter = CLKS_PER_BIT/2 - 1 (integer division) and go to START.
  - START: count down to 0. At 0, if rxd_s=0, load counter = CLKS_PER_BIT-1, clear the bit index and go to DATA. If rxd_s=1, treat it as a glitch and return to IDLE with no flags set.
  - DATA: at each counter expiry, shift rxd_s into shift[7] (LSB first, right shift) and reload the counter. After the 8th sample, go to STOP.
  - STOP: at counter expiry, sample rxd_s.
    - If 1: push the shift register into the FIFO, or set overrun if the FIFO is full and no pop occurs this cycle. Go to IDLE.
    - If 0: set frame_err, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s=1 (handles a break), then go to IDLE.
- Sampling points fall at mid-bit. A start bit stretched by up to CLKS_PER_BIT/2 - 1 extra clocks is still received correctly.
- Latency:
  - The push happens on the clk edge where the stop bit is sampled.
  - rx_valid rises one cycle later when the FIFO was empty.
  - rx_data updates in the same cycle rx_valid rises.
- FIFO:
  - Organised as circular read and write pointers, each $clog2(FIFO_DEPTH) bits, wrapping at FIFO_DEPTH-1 to 0.
  - fifo_count is incremented on a push, decremented on a pop, and unchanged when both occur in the same cycle.
  - Full with a simultaneous push and pop: the push is accepted and overrun is not set.
  - Empty with a push: no pop is possible that cycle.
  - rx_ready while rx_valid=0 has no effect.
- Sticky flags:
  - Set and clear in the same cycle: set wins.
  - The flags never block reception.

Decomposition:
- Shared package uart_pkg holds:
  - the rx FSM state encoding: IDLE, START, DATA, STOP, WAIT_HIGH (3-bit localparams);
  - the UART_DATA_BITS=8 constant;
  - a function for the default CLKS_PER_BIT computed from clock and baud values.
- One sub-module, sync_fifo, with parameters WIDTH=8 and DEPTH. It provides push/pop/full/empty/count and an FWFT head. It is reused later by the UART TX path.
- The FSM, synchroniser and flags stay in uart_rx_fifo.

Test Plan:
- Single byte: clk period 40 ns, 8680 ns bits, send 0x34 with the start bit stretched by +1000 ns. Expect rx_valid=1 with rx_data=0x34 one cycle after the stop-bit sample, and frame_err=0.
- Queueing: send 0x34, 0x35, 0x2A, 0x34, 0x32 with rx_ready=0. Expect fifo_count to reach 4 after the 4th byte, the 5th byte (0x32) to set overrun=1, and pops to return 0x34, 0x35, 0x2A, 0x34 in order.
- Glitch: drive rxd low for 50 clk then high. Expect no push, state back in IDLE, and no flags; a following 0x39 is received intact.
- Framing error: send 0x2F with the stop bit held at 0 for 2 bit times. Expect frame_err=1, no push, and no reception until rxd returns high. err_clr then clears frame_err, and a next 0x30 is received.
- Full with push and pop: with the FIFO full, pulse rx_ready on the stop-sample cycle of an incoming 0x33. Expect fifo_count to stay 4, overrun=0, and 0x33 to be the last entry out.
- Reset mid-frame: assert reset during data bit 4 of 0x99 (0x99 = 8'b1001_1001). Expect outputs at reset values immediately; after release, a clean 0x03 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM state encoding, frame width and the
// helper that turns clock/baud rates into clocks-per-bit.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_t;

  // Rounded to the nearest integer so slightly odd ratios still land close.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head shows the oldest entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads 0 while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a FWFT receive FIFO.
// States: IDLE wait start | START verify start | DATA shift bits | STOP check stop | WAIT_HIGH wait break end
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = calc_clks_per_bit(25_000_000, 115_200),
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic [UART_DATA_BITS-1:0]     rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);

  logic                      sync_1;
  logic                      rxd_s;
  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      cnt_zero;
  logic                      stop_sample;
  logic                      push_req;
  logic                      pop_req;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign cnt_zero    = (cnt == '0);
  assign stop_sample = (state == STOP) && cnt_zero;
  assign push_req    = stop_sample & rxd_s;
  assign pop_req     = rx_valid & rx_ready;
  assign rx_valid    = ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      sync_1 <= rxd;
      rxd_s  <= sync_1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            cnt   <= HALF_CNT;
            state <= START;
          end
        end
        START: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (!rxd_s) begin
            cnt     <= BIT_CNT;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift   <= {rxd_s, shift[UART_DATA_BITS-1:1]};
            cnt     <= BIT_CNT;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (!cnt_zero) cnt <= cnt - 1'b1;
          else           state <= rxd_s ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_sample && !rxd_s) frame_err <= 1'b1;
      else if (err_clr)          frame_err <= 1'b0;
      if (push_req && fifo_full && !pop_req) overrun <= 1'b1;
      else if (err_clr)                      overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (shift),
    .pop       (pop_req),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frame table, hand-written
// corner sequences, then random frames against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int CPB   = 217;
  localparam int HALF  = CPB / 2 - 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  logic         m_ferr;
  logic         m_ovr;

  typedef struct {
    logic [7:0] data;
    int         stretch;
    int         stop_low;
    logic       exp_valid;
    logic       exp_ferr;
    int         exp_rise;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] qb[5];
  logic [7:0] fb[4];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .fifo_count (fifo_count)
  );

  always #20 clk = ~clk;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_data_bits(input logic [7:0] d, input int stretch);
    rxd = 1'b0;
    repeat (CPB + stretch) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // rise = negedges into the stop bit at which rx_valid is first seen high.
  task automatic send_frame(input logic [7:0] d, input int stretch, input int stop_low,
                            input int pop_at, output int rise);
    send_data_bits(d, stretch);
    rise = -1;
    if (stop_low > 0) begin
      rxd = 1'b0;
      repeat (stop_low * CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rxd = 1'b1;
      for (int j = 0; j < CPB; j++) begin
        if (j == pop_at) rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        if (rx_valid && rise < 0) rise = j + 1;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check(input logic [7:0] exp);
    chk("pop_valid", rx_valid, 1);
    chk("pop_data", rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_ferr", frame_err, 0);
    chk("clr_ovr", overrun, 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, fifo_count, mq.size());
    chk({tag, "_valid"}, rx_valid, mq.size() != 0);
    if (mq.size() != 0) chk({tag, "_data"}, rx_data, mq[0]);
    chk({tag, "_ferr"}, frame_err, m_ferr);
    chk({tag, "_ovr"}, overrun, m_ovr);
  endtask

  initial begin
    int         rise;
    logic [7:0] d;
    int         s;
    int         sl;
    int         np;

    // Sampling lands HALF+1 clocks after start detection, which trails the
    // falling edge by the 2-flop synchroniser plus one FSM clock.
    tbl[0] = '{8'h34, 25,       0, 1'b1, 1'b0, HALF + 4 - 25};
    tbl[1] = '{8'h00, 0,        0, 1'b1, 1'b0, HALF + 4};
    tbl[2] = '{8'hFF, HALF - 1, 0, 1'b1, 1'b0, 5};
    tbl[3] = '{8'hA5, 0,        1, 1'b0, 1'b1, -1};
    qb = '{8'h34, 8'h35, 8'h2A, 8'h34, 8'h32};
    fb = '{8'h11, 8'h22, 8'h44, 8'h55};

    reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i].data, tbl[i].stretch, tbl[i].stop_low, -1, rise);
      chk("tbl_valid", rx_valid, tbl[i].exp_valid);
      chk("tbl_rise", rise, tbl[i].exp_rise);
      chk("tbl_ferr", frame_err, tbl[i].exp_ferr);
      chk("tbl_count", fifo_count, tbl[i].exp_valid ? 1 : 0);
      if (tbl[i].exp_valid) pop_check(tbl[i].data);
      if (tbl[i].exp_ferr) clear_err();
    end

    for (int k = 0; k < 5; k++) begin
      send_frame(qb[k], 0, 0, -1, rise);
      chk("q_count", fifo_count, (k + 1 < DEPTH) ? k + 1 : DEPTH);
      chk("q_ovr", overrun, k == 4);
    end
    for (int k = 0; k < 4; k++) pop_check(qb[k]);
    chk("q_empty_count", fifo_count, 0);
    chk("q_empty_valid", rx_valid, 0);
    clear_err();

    rxd = 1'b0;
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", frame_err, 0);
    chk("glitch_ovr", overrun, 0);
    send_frame(8'h39, 0, 0, -1, rise);
    chk("glitch_next_count", fifo_count, 1);
    pop_check(8'h39);

    send_data_bits(8'h2F, 0);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    chk("fe_ferr", frame_err, 1);
    chk("fe_count", fifo_count, 0);
    repeat (CPB) @(negedge clk);
    chk("fe_hold_count", fifo_count, 0);
    chk("fe_hold_valid", rx_valid, 0);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    clear_err();
    send_frame(8'h30, 0, 0, -1, rise);
    chk("fe_next_count", fifo_count, 1);
    chk("fe_next_ferr", frame_err, 0);
    pop_check(8'h30);

    for (int k = 0; k < 4; k++) send_frame(fb[k], 0, 0, -1, rise);
    chk("full_count", fifo_count, 4);
    chk("full_ovr", overrun, 0);
    // Pop request lands on the posedge that samples the stop bit.
    send_frame(8'h33, 0, 0, HALF + 3, rise);
    chk("pp_count", fifo_count, 4);
    chk("pp_ovr", overrun, 0);
    pop_check(8'h22);
    pop_check(8'h44);
    pop_check(8'h55);
    chk("pp_last_data", rx_data, 8'h33);
    chk("pp_last_count", fifo_count, 1);

    d = 8'h99;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = d[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_data", rx_data, 0);
    chk("mrst_count", fifo_count, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_ovr", overrun, 0);
    @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    chk("mrst_idle_count", fifo_count, 0);
    send_frame(8'h03, 0, 0, -1, rise);
    chk("mrst_next_count", fifo_count, 1);
    chk("mrst_next_ferr", frame_err, 0);
    pop_check(8'h03);

    mq.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      s  = int'($urandom_range(0, HALF - 1));
      sl = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send_frame(d, s, sl, -1, rise);
      if (sl > 0)                m_ferr = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(d);
      else                       m_ovr = 1'b1;
      check_model("rnd");
      np = int'($urandom_range(0, 2));
      for (int p = 0; p < np; p++) begin
        if (mq.size() > 0) begin
          pop_check(mq.pop_front());
        end else begin
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
          chk("rnd_idle_pop_count", fifo_count, 0);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      check_model("rnd_post");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
